// File: rtl/gf2p4_inv_pipe.sv
// Two-stage valid/ready pipeline computing the GF(2^4) multiplicative inverse
// over a GF(2^2) normal-basis tower; also counts completed output transfers.
module gf2p4_inv_pipe #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [CNT_W-1:0] done_cnt
);

  function automatic logic [1:0] gf_mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  function automatic logic [1:0] gf_sqsc(input logic [1:0] a);
    return {a[1], a[0] ^ a[1]};
  endfunction

  function automatic logic [1:0] gf_inv(input logic [1:0] a);
    return {a[0], a[1]};
  endfunction

  logic [2:1]       vld_q, vld_d;
  logic [1:0]       hi_q, hi_d, lo_q, lo_d, dd_q, dd_d;
  logic [3:0]       res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv1, adv2, acc;
  logic [1:0]       dinv;

  assign adv2      = !vld_q[2] || out_ready;
  assign adv1      = !vld_q[1] || adv2;
  assign acc       = in_valid && adv1;
  assign in_ready  = adv1;
  assign out_valid = vld_q[2];
  assign out_data  = res_q;
  assign done_cnt  = cnt_q;
  assign dinv      = gf_inv(dd_q);

  always_comb begin
    vld_d = vld_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    dd_d  = dd_q;
    res_d = res_q;
    cnt_d = cnt_q;
    if (flush) begin
      // Flush wins over any same-cycle accept/advance; data regs just hold.
      vld_d = 2'b00;
    end else begin
      if (adv1) begin
        vld_d[1] = acc;
        if (acc) begin
          hi_d = in_data[3:2];
          lo_d = in_data[1:0];
          dd_d = gf_sqsc(in_data[3:2] ^ in_data[1:0]) ^ gf_mul(in_data[3:2], in_data[1:0]);
        end
      end
      if (adv2) begin
        vld_d[2] = vld_q[1];
        if (vld_q[1]) res_d = {gf_mul(dinv, lo_q), gf_mul(dinv, hi_q)};
      end
      if (vld_q[2] && out_ready) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 2'b00;
      hi_q  <= 2'b00;
      lo_q  <= 2'b00;
      dd_q  <= 2'b00;
      res_q <= 4'h0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dd_q  <= dd_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gf2p4_inv_pipe.sv
// Directed bench for gf2p4_inv_pipe: scoreboard of expected inverses plus
// latency, backpressure, flush, async reset and counter-wrap checks.
module tb_gf2p4_inv_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, in_ready2, out_valid2;
  logic [3:0] out_data, out_data2;
  logic [7:0] done_cnt, c0;
  logic [1:0] done_cnt2;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];
  logic [3:0] outs[$];
  logic [1:0] wrap_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  always #5 clk = ~clk;

  gf2p4_inv_pipe #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .done_cnt(done_cnt));

  gf2p4_inv_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .done_cnt(done_cnt2));

  // Reference tower-field inverse.
  function automatic logic [1:0] m_mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = ^a & ^b;
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  function automatic logic [3:0] m_inv(input logic [3:0] x);
    logic [1:0] h, l, s, d, di;
    h  = x[3:2];
    l  = x[1:0];
    s  = h ^ l;
    d  = {s[1], s[1] ^ s[0]} ^ m_mul(h, l);
    di = {d[0], d[1]};
    return {m_mul(di, l), m_mul(di, h)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: outputs are compared just before their transfer edge.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow: got output %0h expected none", out_data);
        end
        if (sb.size() != 0) chk("sb_order", out_data, sb.pop_front());
        outs.push_back(out_data);
      end
      if (in_valid && in_ready) sb.push_back(m_inv(in_data));
    end
  end

  task automatic send(input logic [3:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic single(input logic [3:0] x, input logic [3:0] y, input string tag);
    send(x);
    chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, out_valid, 1);
    chk(tag, out_data, y);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    do_reset();
    chk("post_rst_in_ready", in_ready, 1);

    // Single operands, no stall
    single(4'b0100, 4'b0011, "op_0100");
    single(4'b0001, 4'b1100, "op_0001");
    single(4'b1111, 4'b1111, "op_1111");
    single(4'b0000, 4'b0000, "op_0000");

    // Involution over all 16 values, streamed back-to-back
    do_reset();
    outs.delete();
    for (int i = 0; i < 16; i++) begin
      in_data = 4'(i); in_valid = 1'b1;
      #1 chk("stream_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("stream1_cnt", done_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      in_data = outs[i]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("stream2_cnt", done_cnt, 32);
    for (int i = 0; i < 16; i++) chk("involution", outs[16+i], i);

    // Backpressure
    outs.delete();
    out_ready = 1'b0;
    send(4'b0001);
    send(4'b0100);
    in_data = 4'b1111; in_valid = 1'b1;
    #1 chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_hold", out_data, 4'b1100);
      chk("bp_in_ready_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("bp_sb_empty", sb.size(), 0);
    chk("bp_cnt", done_cnt, 35);
    chk("bp_n_out", outs.size(), 3);
    if (outs.size() == 3) begin
      chk("bp_out0", outs[0], 4'b1100);
      chk("bp_out1", outs[1], 4'b0011);
      chk("bp_out2", outs[2], 4'b1111);
    end

    // Flush with both stages full and a pending operand
    out_ready = 1'b0;
    send(4'h5);
    send(4'h6);
    in_data = 4'h7; in_valid = 1'b1; flush = 1'b1;
    c0 = done_cnt;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_cnt", done_cnt, c0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("flush_drain_valid", out_valid, 0);
    chk("flush_drain_cnt", done_cnt, c0);

    // Async reset between edges with two operands in flight
    out_ready = 1'b0;
    send(4'h1);
    send(4'h2);
    #3 rst = 1'b1;
    #1 chk("arst_out_valid", out_valid, 0);
    chk("arst_done_cnt", done_cnt, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk); @(negedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    single(4'b0011, 4'b0100, "arst_op_0011");

    // Counter wrap on the CNT_W=2 instance
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(4'(k + 3));
      repeat (2) @(posedge clk);
      #1 chk("wrap_cnt", done_cnt2, wrap_exp[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf2p4_inv_pipe.md
GF2P4_INV_PIPE -- requirements
Module: gf2p4_inv_pipe

Interface
REQ-001 Parameter: CNT_W, default 8, width of the completed-transfer counter.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: flush  input  1  synchronous pipeline clear.
REQ-005 Port: in_valid  input  1  in_data is valid.
REQ-006 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port: in_data  input  4  GF(2^4) operand: [3:2] = hi, [1:0] = lo; each is a GF(2^2) normal-basis pair.
REQ-008 Port: out_valid  output  1  out_data is valid.
REQ-009 Port: out_ready  input  1  downstream accepts out_data.
REQ-010 Port: out_data  output  4  GF(2^4) inverse of the accepted operand: [3:2] = hi', [1:0] = lo'.
REQ-011 Port: done_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-012 GF(2^2) ops on (a1,a0): sqsc(a) = (a1, a0^a1); inv(a) = (a0, a1), a bit swap; mul(a,b): e = (a1^a0)&(b1^b0), p1 = (a1&b1)^e, p0 = (a0&b0)^e.
REQ-013 Stage 1 shall register d = sqsc(hi^lo) ^ mul(hi,lo), together with hi and lo.
REQ-014 Stage 2 shall register hi' = mul(inv(d), lo) and lo' = mul(inv(d), hi).
REQ-015 An input of 4'h0 shall produce 4'h0 with no special-case logic.
REQ-016 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-017 Latency shall be exactly 2 cycles from the input-transfer edge to out_valid, when there is no stall.
REQ-018 Definitions: v1 and v2 are the stage valid bits; adv2 = !v2 || out_ready; adv1 = !v1 || adv2.
REQ-019 in_ready shall equal adv1 combinationally; throughput shall be one operand per cycle while out_ready = 1.
REQ-020 While out_ready = 0 and both stages are full: in_ready = 0, and out_data and stage-1 contents shall hold stable.
REQ-021 out_valid = v2; out_data shall not change while out_valid && !out_ready.
REQ-022 Results shall leave in acceptance order; there shall be no loss and no duplication.
REQ-023 flush = 1 shall clear v1 and v2 at the next edge, shall override same-cycle acceptance and advance, and shall leave done_cnt unchanged.
REQ-024 While flush = 1, in_ready shall still follow REQ-019, but any accepted operand is discarded.
REQ-025 done_cnt shall increment by 1 on each output transfer, shall wrap from 2^CNT_W-1 to 0, and shall not increment on a flush edge.
REQ-026 Data registers shall load only when their stage advances with valid data; in all other cycles they shall hold.

Reset
REQ-027 rst = 1 shall immediately force v1 = 0, v2 = 0, out_valid = 0, out_data = 4'h0, done_cnt = 0, and all stage data registers = 0.
REQ-028 in_ready shall be 1 during and after reset, because both stages are empty.
REQ-029 Reset asserted mid-operation shall discard all in-flight operands; the first result after release is from the first operand accepted after release.

Verification
REQ-030 Single operands with out_ready = 1: 4'b0100 -> 4'b0011; 4'b0001 -> 4'b1100; 4'b1111 -> 4'b1111; 4'b0000 -> 4'b0000; each exactly 2 cycles after acceptance.
REQ-031 Exhaustive involution: stream all 16 values back-to-back, feed each result back in, and check the second result equals the original; throughput 1 per cycle, done_cnt = 32.
REQ-032 Backpressure: stream 0001, 0100, 1111, hold out_ready = 0 for 5 cycles, then release -> in_ready = 0 after 2 accepts, out_data = 4'b1100 held stable, then 1100, 0011, 1111 in order.
REQ-033 Flush with both stages full and in_valid = 1 -> next cycle out_valid = 0, no output transfers, done_cnt unchanged.
REQ-034 Async reset asserted between clock edges with 2 operands in flight -> out_valid = 0 and done_cnt = 0 immediately; next accepted 4'b0011 -> 4'b0100.
REQ-035 Counter wrap with CNT_W = 2: 5 output transfers -> done_cnt sequence 1, 2, 3, 0, 1.
